// File: rtl/mac_acc_pkg.sv
// Shared widths, output-register state encoding and the saturating adder
// used by the product accumulator.
package mac_acc_pkg;

    localparam int unsigned DEF_PROD_W = 16;
    localparam int unsigned DEF_ACC_W  = 24;
    localparam int unsigned DEF_TERMS  = 4;

    // Working width of sat_add; accumulators up to this width are supported.
    localparam int unsigned SAT_W  = 64;
    localparam int unsigned SAT_W1 = SAT_W + 1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Returns {ovf, sum}: acc + prod clamped to 2^acc_w-1, ovf set when clamped.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] acc,
        input logic [SAT_W-1:0] prod,
        input int unsigned      acc_w
    );
        logic [SAT_W:0] s;
        logic [SAT_W:0] lim;
        s   = {1'b0, acc} + {1'b0, prod};
        lim = (SAT_W1'(1) << acc_w) - SAT_W1'(1);
        if (s > lim) begin
            return {1'b1, lim[SAT_W-1:0]};
        end
        return {1'b0, s[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/mac_acc_lane.sv
// One accumulation channel: running sum, term count and sticky overflow.
// The _c outputs show what this accept produces so the top can capture
// a completed sum on the same edge the lane clears itself.
module mac_acc_lane
    import mac_acc_pkg::*;
#(
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned TERMS  = DEF_TERMS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  next_sum_c,
    output logic              next_ovf_c,
    output logic              done_c
);

    localparam int unsigned CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [SAT_W:0]   add_res;
    logic             unused_add_res;

    // Saturating sum including the presented product, and completion detect.
    always_comb begin
        add_res    = sat_add(SAT_W'(acc), SAT_W'(product), ACC_W);
        next_sum_c = add_res[ACC_W-1:0];
        next_ovf_c = ovf | add_res[SAT_W];
        done_c     = add & (cnt == CNT_W'(TERMS - 1));
    end

    // Upper bits of the wide adder result are zero by construction.
    assign unused_add_res = ^add_res;

    // Lane state: cleared by reset, flush or completion; otherwise accumulates.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (add) begin
            if (done_c) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= next_sum_c;
                cnt <= cnt + CNT_W'(1);
                ovf <= next_ovf_c;
            end
        end
    end

endmodule

// File: rtl/mac_product_accumulator.sv
// Two-channel product accumulator between the 8x8 multiplier and writeback.
// Each channel sums TERMS products; the completed sum is presented through
// a one-entry output register with valid/ready flow control.
module mac_product_accumulator
    import mac_acc_pkg::*;
#(
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned TERMS  = DEF_TERMS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_sel,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_chan,
    output logic              out_ovf
);

    out_state_t       state;
    out_state_t       state_n;

    logic             accept;
    logic             out_xfer;
    logic             add0;
    logic             add1;
    logic [ACC_W-1:0] sum0_c;
    logic [ACC_W-1:0] sum1_c;
    logic             ovf0_c;
    logic             ovf1_c;
    logic             done0_c;
    logic             done1_c;
    logic             done_any;

    // Input may only move when the output slot is free or draining this cycle.
    assign in_ready = !clr & (!out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign add0     = accept & !in_sel;
    assign add1     = accept &  in_sel;
    assign done_any = done0_c | done1_c;

    mac_acc_lane #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .TERMS  (TERMS)
    ) u_lane0 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .add        (add0),
        .product    (in_product),
        .next_sum_c (sum0_c),
        .next_ovf_c (ovf0_c),
        .done_c     (done0_c)
    );

    mac_acc_lane #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .TERMS  (TERMS)
    ) u_lane1 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .add        (add1),
        .product    (in_product),
        .next_sum_c (sum1_c),
        .next_ovf_c (ovf1_c),
        .done_c     (done1_c)
    );

    // Output slot state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Output slot next state: fill on completion, drain unless refilled.
    always_comb begin
        state_n = state;
        case (state)
            OUT_EMPTY: begin
                if (done_any) begin
                    state_n = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_xfer && !done_any) begin
                    state_n = OUT_EMPTY;
                end
            end
            default: state_n = OUT_EMPTY;
        endcase
    end

    assign out_valid = (state == OUT_FULL);

    // Result payload: captured from the completing lane, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum  <= '0;
            out_chan <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (done_any) begin
            out_sum  <= done1_c ? sum1_c : sum0_c;
            out_chan <= done1_c;
            out_ovf  <= done1_c ? ovf1_c : ovf0_c;
        end
    end

endmodule
